friet_permutation_axi4_lite_master: RTL and testbench
=====================================================

// Module: friet_permutation_axi4_lite_master
// PURPOSE
//  AXI4-Lite initiator that drives one Friet permutation peripheral end to end.
//  - Takes a 384-bit state from local logic on a start pulse.
//  - Writes the state as 12 words, then writes the start command.
//  - Reads back 12 result words and the fault flag, then reports done, error and fault.
//  - Sits between a local sponge/mode controller and the AXI4-Lite slave port of the permutation.
// PARAMETERS
//  STATE_WORDS     12     32-bit words per 384-bit state
//  ADDR_STATE_OUT  4'h0   read address of the state output word
//  ADDR_STATE_IN   4'h4   write address of the state input word
//  ADDR_START      4'h8   write address of the start command
//  ADDR_FAULT      4'hB   read address of the fault status (bit 0)
//  TIMEOUT_CYCLES  1024   watchdog limit per handshake (FRIET_MASTER_TIMEOUT_EN only)
// PORTS
//  aclk           in   1    clock
//  aresetn        in   1    synchronous reset, active-low
//  start          in   1    pulse: latch state_in, begin sequence (IDLE only)
//  state_in       in   384  input state; word i = state_in[32*i+:32]
//  busy           out  1    sequence in progress
//  done           out  1    one-cycle pulse: sequence finished
//  state_out      out  384  result state; word i = state_out[32*i+:32]
//  fault          out  1    fault bit read from ADDR_FAULT, valid with done
//  error          out  1    non-OKAY response or timeout, valid with done
//  m_axi_aw*      out       awaddr[3:0], awprot[2:0]=0, awvalid; awready in
//  m_axi_w*       out       wdata[31:0], wstrb[3:0]=4'hF, wvalid; wready in
//  m_axi_b*                 bresp[1:0] in, bvalid in, bready out
//  m_axi_ar*      out       araddr[3:0], arprot[2:0]=0, arvalid; arready in
//  m_axi_r*                 rdata[31:0] in, rresp[1:0] in, rvalid in, rready out
// BEHAVIOUR
//  - Reset: every output is 0 on the first aclk edge with aresetn=0. This includes valids, readies, state_out, busy, done, fault and error.
//  - Reset mid-transaction abandons the sequence; the FSM returns to IDLE.
//  - FSM states and transitions:
//    - IDLE: start=1 latches state_in, clears word counter, error and fault; go to WR.
//    - WR: issue write of word[cnt] to ADDR_STATE_IN. cnt 0..11, word 0 first. After the last word, go to WS.
//    - WS: write 32'h1 to ADDR_START, then go to RD.
//    - RD: read ADDR_STATE_OUT 12 times; rdata of read k goes to state_out[32*k+:32]. Then go to RF.
//    - RF: read ADDR_FAULT; fault = rdata[0]. Then go to FIN.
//    - FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
//  - Write handshake:
//    - awvalid and wvalid rise together.
//    - Each is held with addr/data stable until its own ready is sampled high; the two drop independently.
//    - bready is 1 from first issue until bvalid is sampled; only then does the next transaction start.
//    - At most one write is outstanding.
//  - Read handshake:
//    - arvalid is held until arready is sampled high.
//    - rready is 1 until rvalid is sampled high.
//    - At most one read is outstanding.
//  - The slave deasserts ready while the core computes. The master just waits; there is no polling loop.
//  - Errors:
//    - bresp or rresp != 2'b00 sets error=1 and jumps to FIN after that response.
//    - On this abort, state_out words not yet read stay 0.
//  - Inputs are ignored outside their phase:
//    - start while busy.
//    - Spurious bvalid or rvalid while no transaction is outstanding.
//  - Latency with always-ready, one-cycle-response slave: about 3 cycles per transaction, 26 transactions.
// CONFIGURATION
//  - FRIET_MASTER_TIMEOUT_EN defined:
//    - A counter restarts at each transaction issue.
//    - Reaching TIMEOUT_CYCLES before the pending ready/response drops all valids, sets error=1 and goes to FIN.
//  - Not defined: no counter; the master waits indefinitely.
// STRUCTURE
//  - Package friet_axi_lite_pkg holds:
//    - address constants;
//    - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
//    - FSM state enum;
//    - STATE_WORDS.
//  - Sub-module axi4_lite_single_beat_master:
//    - takes a request (rw, addr, wdata) and returns ack, rdata and resp;
//    - owns all five channels and the handshake rules.
//  - The top holds the FSM, word counter and state buffers.
// TESTING
//  1. Always-ready slave model; state_in = words 32'h0..32'hB, echo mode.
//     -> 12 writes to 0x4 (wdata 0..B), then a 0x8 write of 32'h1.
//     -> 12 reads of 0x0 are stored in order, one read of 0xB follows, done pulses once with error=0.
//  2. awready delayed 3 cycles, wready delayed 5 cycles.
//     -> awvalid and wvalid each stay high with stable addr/data until their own ready; no duplicate write.
//  3. Slave returns bresp=2'b10 on word 5.
//     -> No further transactions; done with error=1; busy drops the next cycle.
//  4. Slave fault register reads 32'h1.
//     -> fault=1 with done; state_out holds the 12 read words.
//  5. aresetn=0 during the RD phase.
//     -> All outputs 0 the next cycle; a new start runs a clean full sequence.
//  6. FRIET_MASTER_TIMEOUT_EN with arready stuck at 0.
//     -> After TIMEOUT_CYCLES, arvalid drops, error=1, done pulses.
//     -> start pulsed while busy is ignored.

Source files
------------

// File: rtl/friet_axi_lite_pkg.sv
// Purpose : shared constants, FSM state encoding and request payload for the
//           Friet permutation AXI4-Lite master.
// Contents: register map, AXI response codes, sizes, fsm_state_t, beat_req_t.
package friet_axi_lite_pkg;

  localparam int unsigned STATE_WORDS    = 12;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned STATE_W        = STATE_WORDS * WORD_W;
  localparam int unsigned ADDR_W         = 4;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned LSB_W          = $clog2(WORD_W);
  localparam int unsigned OFS_W          = CNT_W + LSB_W;
  localparam int unsigned TIMEOUT_CYCLES = 1024;
  localparam int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES);

  localparam logic [ADDR_W-1:0] ADDR_STATE_OUT = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_STATE_IN  = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_START     = 4'h8;
  localparam logic [ADDR_W-1:0] ADDR_FAULT     = 4'hB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WS,
    S_RD,
    S_RF,
    S_FIN
  } fsm_state_t;

  // One single-beat bus request: rw=1 write, rw=0 read.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } beat_req_t;

endpackage

// File: rtl/friet_permutation_axi4_lite_master_if.sv
// Purpose : AXI4-Lite bus bundle between the Friet master and the peripheral.
// Modports: master (drives AW/W/AR, bready, rready), slave (the reverse).
interface friet_permutation_axi4_lite_master_if;
  import friet_axi_lite_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [WORD_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [WORD_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi4_lite_single_beat_master.sv
// Purpose : runs one AXI4-Lite read or write at a time on all five channels.
// Ports   : aclk, aresetn (sync, active-low); req/req_data accepted only when
//           no beat is outstanding; ack pulses with rdata/resp when the beat
//           completes; m_axi master modport.
// Option  : FRIET_MASTER_TIMEOUT_EN adds a per-beat watchdog that abandons
//           the beat and reports RESP_SLVERR.
module axi4_lite_single_beat_master
  import friet_axi_lite_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req,
  input  beat_req_t         req_data,
  output logic              ack,
  output logic [WORD_W-1:0] rdata,
  output logic [1:0]        resp,
  friet_permutation_axi4_lite_master_if.master m_axi
);

  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;

`ifdef FRIET_MASTER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
`endif

  // bready / rready double as the "write / read outstanding" flags.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axi.awaddr  <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wstrb   <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
      ack           <= 1'b0;
      rdata         <= '0;
      resp          <= '0;
`ifdef FRIET_MASTER_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      ack <= 1'b0;
      if (!m_axi.bready && !m_axi.rready) begin
        if (req) begin
`ifdef FRIET_MASTER_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (req_data.rw) begin
            m_axi.awaddr  <= req_data.addr;
            m_axi.awvalid <= 1'b1;
            m_axi.wdata   <= req_data.wdata;
            m_axi.wstrb   <= 4'hF;
            m_axi.wvalid  <= 1'b1;
            m_axi.bready  <= 1'b1;
          end else begin
            m_axi.araddr  <= req_data.addr;
            m_axi.arvalid <= 1'b1;
            m_axi.rready  <= 1'b1;
          end
        end
      end else begin
`ifdef FRIET_MASTER_TIMEOUT_EN
        // Watchdog first; a response landing on the same edge overrides it.
        if (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          m_axi.awvalid <= 1'b0;
          m_axi.wvalid  <= 1'b0;
          m_axi.bready  <= 1'b0;
          m_axi.arvalid <= 1'b0;
          m_axi.rready  <= 1'b0;
          resp          <= RESP_SLVERR;
          ack           <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
        end
`endif
        if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
        if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
        if (m_axi.arvalid && m_axi.arready) m_axi.arvalid <= 1'b0;
        // A response always closes the beat.
        if (m_axi.bready && m_axi.bvalid) begin
          m_axi.bready  <= 1'b0;
          m_axi.awvalid <= 1'b0;
          m_axi.wvalid  <= 1'b0;
          resp          <= m_axi.bresp;
          ack           <= 1'b1;
        end
        if (m_axi.rready && m_axi.rvalid) begin
          m_axi.rready  <= 1'b0;
          m_axi.arvalid <= 1'b0;
          rdata         <= m_axi.rdata;
          resp          <= m_axi.rresp;
          ack           <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/friet_permutation_axi4_lite_master.sv
// Purpose : drives one Friet permutation peripheral end to end: writes the
//           12-word state, writes start, reads 12 result words and the fault
//           flag, then pulses done with error/fault.
// Ports   : aclk, aresetn (sync, active-low), start, state_in[383:0] in;
//           busy, done, state_out[383:0], fault, error out; m_axi master.
// Option  : FRIET_MASTER_TIMEOUT_EN enables the per-beat watchdog in the
//           single-beat master; a timeout surfaces here as error.
module friet_permutation_axi4_lite_master
  import friet_axi_lite_pkg::*;
(
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state_out,
  output logic               fault,
  output logic               error,
  friet_permutation_axi4_lite_master_if.master m_axi
);

  fsm_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wait_q, wait_d;
  logic [STATE_W-1:0] buf_q, buf_d, sout_d;
  logic               err_d, fault_d, busy_d, done_d;
  logic               req_c, last_word_c;
  beat_req_t          req_data_c;
  logic [OFS_W-1:0]   word_lsb_c;
  logic               beat_ack;
  logic [WORD_W-1:0]  beat_rdata;
  logic [1:0]         beat_resp;

  axi4_lite_single_beat_master u_beat (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .req      (req_c),
    .req_data (req_data_c),
    .ack      (beat_ack),
    .rdata    (beat_rdata),
    .resp     (beat_resp),
    .m_axi    (m_axi)
  );

  // Sequencer: one request per phase step, advance only on its ack.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    buf_d       = buf_q;
    sout_d      = state_out;
    err_d       = error;
    fault_d     = fault;
    req_c       = 1'b0;
    req_data_c  = '0;
    word_lsb_c  = {cnt_q, {LSB_W{1'b0}}};
    last_word_c = (cnt_q == CNT_W'(STATE_WORDS - 1));

    case (state_q)
      S_WR: begin
        req_data_c.rw    = 1'b1;
        req_data_c.addr  = ADDR_STATE_IN;
        req_data_c.wdata = buf_q[word_lsb_c +: WORD_W];
      end
      S_WS: begin
        req_data_c.rw    = 1'b1;
        req_data_c.addr  = ADDR_START;
        req_data_c.wdata = WORD_W'(1);
      end
      S_RD:    req_data_c.addr = ADDR_STATE_OUT;
      S_RF:    req_data_c.addr = ADDR_FAULT;
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d   = state_in;
          cnt_d   = '0;
          wait_d  = 1'b0;
          err_d   = 1'b0;
          fault_d = 1'b0;
          sout_d  = '0;
          state_d = S_WR;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (!wait_q) begin
          req_c  = 1'b1;
          wait_d = 1'b1;
        end else if (beat_ack) begin
          wait_d = 1'b0;
          if (beat_resp != RESP_OKAY) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            case (state_q)
              S_WR: begin
                if (last_word_c) begin
                  cnt_d   = '0;
                  state_d = S_WS;
                end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                end
              end
              S_WS: state_d = S_RD;
              S_RD: begin
                sout_d[word_lsb_c +: WORD_W] = beat_rdata;
                if (last_word_c) begin
                  cnt_d   = '0;
                  state_d = S_RF;
                end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                end
              end
              S_RF: begin
                fault_d = beat_rdata[0];
                state_d = S_FIN;
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    done_d = (state_d == S_FIN);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wait_q    <= 1'b0;
      buf_q     <= '0;
      state_out <= '0;
      error     <= 1'b0;
      fault     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      buf_q     <= buf_d;
      state_out <= sout_d;
      error     <= err_d;
      fault     <= fault_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_friet_permutation_axi4_lite_master.sv
// Purpose : self-checking bench for friet_permutation_axi4_lite_master with a
//           behavioural AXI4-Lite peripheral (echo ^ mask permutation) and a
//           transaction-level expectation model.
// Option  : FRIET_MASTER_TIMEOUT_EN adds the stuck-arready watchdog scenario.
module tb_friet_permutation_axi4_lite_master;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         start;
  logic [383:0] state_in;
  logic         busy, done, fault, error;
  logic [383:0] state_out;

  friet_permutation_axi4_lite_master_if m_axi ();

  friet_permutation_axi4_lite_master dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .state_in  (state_in),
    .busy      (busy),
    .done      (done),
    .state_out (state_out),
    .fault     (fault),
    .error     (error),
    .m_axi     (m_axi)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Peripheral configuration
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit          ar_stuck = 0;
  int          err_idx = -1;
  logic [31:0] fault_val = '0;
  logic [31:0] mask = '0;

  // Peripheral state and observation logs
  logic [31:0] mem [12];
  logic [31:0] outw [12];
  int          wr_words, rd_words, wr_cnt, viol, ar_hi, done_cnt;
  logic [35:0] wr_log [$];
  logic [3:0]  rd_log [$];

  bit          hs_aw, hs_w, hs_b, hs_ar, hs_r, got_aw, got_w, got_ar;
  logic [3:0]  cap_awaddr, cap_araddr, wa, ra, aw_first, ar_first;
  logic [31:0] cap_wdata, wd, w_first;
  int          aw_cnt, w_cnt, ar_cnt;

  task automatic slave_clear();
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    got_aw = 0; got_w = 0; got_ar = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    m_axi.awready = 0; m_axi.wready = 0; m_axi.arready = 0;
    m_axi.bvalid = 0; m_axi.bresp = 0;
    m_axi.rvalid = 0; m_axi.rresp = 0; m_axi.rdata = 0;
  endtask

  // Peripheral: drives on negedge, so valid&&ready seen here is the handshake
  // taken at the following posedge.
  initial begin
    slave_clear();
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        slave_clear();
        continue;
      end
      if (done === 1'b1) done_cnt++;
      if (m_axi.arvalid === 1'b1) ar_hi++;
      if (hs_aw) begin got_aw = 1; wa = cap_awaddr; end
      if (hs_w)  begin got_w = 1;  wd = cap_wdata;  end
      if (hs_b)  m_axi.bvalid = 0;
      if (hs_ar) begin got_ar = 1; ra = cap_araddr; end
      if (hs_r)  m_axi.rvalid = 0;
      if (got_aw && got_w) begin
        got_aw = 0; got_w = 0;
        wr_log.push_back({wa, wd});
        if (wa == 4'h4 && wr_words < 12) begin
          mem[wr_words] = wd;
          wr_words++;
        end else if (wa == 4'h8 && wd == 32'h1) begin
          for (int k = 0; k < 12; k++) outw[k] = mem[k] ^ mask;
        end
        m_axi.bresp  = (wr_cnt == err_idx) ? 2'b10 : 2'b00;
        m_axi.bvalid = 1;
        wr_cnt++;
      end
      if (got_ar) begin
        got_ar = 0;
        rd_log.push_back(ra);
        m_axi.rdata = '0;
        if (ra == 4'h0 && rd_words < 12) begin
          m_axi.rdata = outw[rd_words];
          rd_words++;
        end else if (ra == 4'hB) begin
          m_axi.rdata = fault_val;
        end
        m_axi.rresp  = 2'b00;
        m_axi.rvalid = 1;
      end
      if (m_axi.awvalid === 1'b1) begin
        aw_cnt++;
        if (aw_cnt == 1) aw_first = m_axi.awaddr;
        else if (m_axi.awaddr !== aw_first) viol++;
      end else aw_cnt = 0;
      if (m_axi.wvalid === 1'b1) begin
        w_cnt++;
        if (m_axi.wstrb !== 4'hF) viol++;
        if (w_cnt == 1) w_first = m_axi.wdata;
        else if (m_axi.wdata !== w_first) viol++;
      end else w_cnt = 0;
      if (m_axi.arvalid === 1'b1) begin
        ar_cnt++;
        if (ar_cnt == 1) ar_first = m_axi.araddr;
        else if (m_axi.araddr !== ar_first) viol++;
      end else ar_cnt = 0;
      m_axi.awready = (m_axi.awvalid === 1'b1) && (aw_cnt > aw_dly);
      m_axi.wready  = (m_axi.wvalid === 1'b1) && (w_cnt > w_dly);
      m_axi.arready = (m_axi.arvalid === 1'b1) && !ar_stuck && (ar_cnt > ar_dly);
      hs_aw = m_axi.awready;
      hs_w  = m_axi.wready;
      hs_ar = m_axi.arready;
      hs_b  = m_axi.bvalid && (m_axi.bready === 1'b1);
      hs_r  = m_axi.rvalid && (m_axi.rready === 1'b1);
      cap_awaddr = m_axi.awaddr;
      cap_wdata  = m_axi.wdata;
      cap_araddr = m_axi.araddr;
    end
  end

  function automatic logic [383:0] rand_state();
    logic [383:0] s;
    for (int k = 0; k < 12; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  task automatic clear_logs();
    wr_log.delete(); rd_log.delete();
    wr_words = 0; rd_words = 0; wr_cnt = 0; viol = 0; done_cnt = 0; ar_hi = 0;
  endtask

  task automatic chk_reset(input string tag);
    check_eq({tag, " ctrl"}, {busy, done, fault, error}, '0);
    check_eq({tag, " state_out"}, state_out, '0);
    check_eq({tag, " bus"}, {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid,
                             m_axi.rready, m_axi.awaddr, m_axi.araddr, m_axi.wdata,
                             m_axi.wstrb, m_axi.awprot, m_axi.arprot}, '0);
  endtask

  task automatic pulse_start(input logic [383:0] st);
    state_in = st;
    @(negedge aclk); start = 1;
    @(negedge aclk); start = 0;
  endtask

  // Full sequence against the transaction-level expectation.
  task automatic run_seq(input string name, input logic [383:0] st, input int e_idx,
                         input logic [31:0] fv, input logic [31:0] msk);
    logic [35:0]  exp_wr [$];
    logic [3:0]   exp_rd [$];
    logic [383:0] exp_out;
    int           n_wr, c;
    err_idx = e_idx; fault_val = fv; mask = msk;
    clear_logs();
    n_wr = (e_idx >= 0) ? e_idx + 1 : 13;
    for (int k = 0; k < n_wr && k < 13; k++)
      exp_wr.push_back((k < 12) ? {4'h4, st[32*k +: 32]} : {4'h8, 32'h1});
    exp_out = '0;
    if (e_idx < 0) begin
      for (int k = 0; k < 12; k++) begin
        exp_rd.push_back(4'h0);
        exp_out[32*k +: 32] = st[32*k +: 32] ^ msk;
      end
      exp_rd.push_back(4'hB);
    end
    pulse_start(st);
    check_eq({name, " busy_after_start"}, busy, 1);
    c = 0;
    while (done !== 1'b1 && c < 6000) begin @(negedge aclk); c++; end
    check_eq({name, " done_seen"}, done, 1);
    if (done === 1'b1) begin
      check_eq({name, " error"}, error, (e_idx >= 0));
      check_eq({name, " fault"}, fault, (e_idx < 0) ? fv[0] : 1'b0);
      check_eq({name, " state_out"}, state_out, exp_out);
      @(negedge aclk);
      check_eq({name, " busy_done_after"}, {busy, done}, 2'b00);
    end
    repeat (4) @(negedge aclk);
    check_eq({name, " n_writes"}, wr_log.size(), exp_wr.size());
    check_eq({name, " n_reads"}, rd_log.size(), exp_rd.size());
    for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++)
      check_eq($sformatf("%s wr%0d", name, k), wr_log[k], exp_wr[k]);
    for (int k = 0; k < exp_rd.size() && k < rd_log.size(); k++)
      check_eq($sformatf("%s rd%0d", name, k), rd_log[k], exp_rd[k]);
    check_eq({name, " stable"}, viol, 0);
    check_eq({name, " done_pulses"}, done_cnt, 1);
  endtask

  task automatic reset_in_rd();
    int c;
    err_idx = -1; fault_val = 0; mask = $urandom;
    clear_logs();
    pulse_start(rand_state());
    c = 0;
    while (rd_log.size() < 3 && c < 2000) begin @(negedge aclk); c++; end
    check_eq("t5 reached_rd", (rd_log.size() >= 3), 1);
    aresetn = 0;
    @(negedge aclk);
    chk_reset("t5 rst");
    @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
    run_seq("t5_rerun", rand_state(), -1, 32'h0, $urandom);
  endtask

`ifdef FRIET_MASTER_TIMEOUT_EN
  task automatic timeout_test();
    int c;
    err_idx = -1; fault_val = 0; mask = 0;
    clear_logs();
    ar_stuck = 1;
    pulse_start(rand_state());
    c = 0;
    while (m_axi.arvalid !== 1'b1 && c < 1000) begin @(negedge aclk); c++; end
    check_eq("t6 arvalid_seen", m_axi.arvalid, 1);
    repeat (20) @(negedge aclk);
    start = 1;
    @(negedge aclk);
    start = 0;
    c = 0;
    while (done !== 1'b1 && c < 3000) begin @(negedge aclk); c++; end
    check_eq("t6 done_seen", done, 1);
    check_eq("t6 error", error, 1);
    check_eq("t6 arvalid_dropped", m_axi.arvalid, 0);
    check_eq("t6 arvalid_cycles", ar_hi, 1024);
    repeat (10) @(negedge aclk);
    check_eq("t6 busy_idle", busy, 0);
    check_eq("t6 n_writes", wr_log.size(), 13);
    check_eq("t6 n_reads", rd_log.size(), 0);
    check_eq("t6 done_pulses", done_cnt, 1);
    ar_stuck = 0;
  endtask
`endif

  initial begin
    logic [383:0] st1;
    int           e;
    aresetn  = 0;
    start    = 0;
    state_in = '0;
    @(negedge aclk);
    chk_reset("reset");
    repeat (2) @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);

    for (int k = 0; k < 12; k++) st1[32*k +: 32] = k;
    run_seq("t1_echo", st1, -1, 32'h0, 32'h0);

    aw_dly = 3; w_dly = 5;
    run_seq("t2_delay", rand_state(), -1, 32'h0, $urandom);
    aw_dly = 0; w_dly = 0;

    run_seq("t3_bresp", rand_state(), 5, 32'h0, 32'h0);
    run_seq("t4_fault", rand_state(), -1, 32'h1, $urandom);

    reset_in_rd();

    for (int i = 0; i < 4; i++) begin
      aw_dly = $urandom_range(0, 4);
      w_dly  = $urandom_range(0, 4);
      ar_dly = $urandom_range(0, 4);
      e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_seq($sformatf("rnd%0d", i), rand_state(), e, $urandom, $urandom);
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0;

`ifdef FRIET_MASTER_TIMEOUT_EN
    timeout_test();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
